// File: rtl/pc_redirect_pkg.sv
// Shared opcode codes, FSM state encodings and control-transfer classification
// for the fetch-PC redirect logic.
package pc_redirect_pkg;

  typedef logic [31:0] word_t;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  // True for the three opcodes that can move the PC off the sequential path.
  function automatic logic is_ctl(input logic [4:0] opcode);
    return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
  endfunction

endpackage

// File: rtl/pc_redirect_unit_target_gen.sv
// Combinational target computation: PC- or rs1-relative adder, JALR bit-0 clear,
// and the misaligned-target check for a taken transfer.
module target_gen
  import pc_redirect_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic        i_taken,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1,
  output logic [31:0] o_target,
  output logic        o_bad
);

  logic        w_is_jalr;
  logic [31:0] w_base;
  logic [31:0] w_sum;

  assign w_is_jalr = (i_opcode == OPC_JALR);
  assign w_base    = w_is_jalr ? i_rs1 : i_pc;
  assign w_sum     = w_base + i_imm;

  // JALR discards bit 0 of the sum; bit 1 can still leave the target misaligned.
  assign o_target  = w_is_jalr ? {w_sum[31:1], 1'b0} : w_sum;
  assign o_bad     = i_taken && (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the fetch PC: applies EX-stage branch/JAL/JALR redirects, flushes the
// wrong-path slots, parks a redirect while fetch is stalled and counts redirects.
module pc_redirect_unit
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic             ex_flag,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [0:0]       r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_pend_tgt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_misalign;

  logic             w_taken;
  logic             w_taken_run;
  logic             w_accept;
  logic             w_bad;
  logic             w_pend_release;
  logic [31:0]      w_target;

  // A taken transfer seen while PEND is ignored: its younger slots were already flushed.
  assign w_taken        = ex_valid && is_ctl(ex_opcode) && ex_flag;
  assign w_taken_run    = w_taken && (r_state == S_RUN);
  assign w_accept       = w_taken_run && !w_bad;
  assign w_pend_release = (r_state == S_PEND) && !if_stall;

  target_gen u_target_gen (
    .i_opcode (ex_opcode),
    .i_taken  (w_taken_run),
    .i_pc     (ex_pc),
    .i_imm    (ex_imm),
    .i_rs1    (ex_rs1),
    .o_target (w_target),
    .o_bad    (w_bad)
  );

  assign redirect     = !rst && ((w_accept && !if_stall) || w_pend_release);
  assign flush_if_id  = redirect;
  assign flush_id_ex  = !rst && w_accept;
  assign pc           = r_pc;
  assign pc_plus4     = r_pc + 32'd4;
  assign taken_cnt    = r_cnt;
  assign misalign_err = r_misalign;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_pend_tgt <= '0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_taken_run && w_bad;
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (if_stall) begin
              r_pend_tgt <= w_target;
              r_state    <= S_PEND;
            end else begin
              r_pc <= w_target;
            end
          end else if (!if_stall) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        S_PEND: begin
          if (!if_stall) begin
            r_pc    <= r_pend_tgt;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus random
// traffic, compared against a rule-level reference model of fetch-PC behaviour.
module tb_pc_redirect_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_stall;
  logic          ex_valid;
  logic [4:0]    ex_opcode;
  logic          ex_flag;
  logic [31:0]   ex_pc;
  logic [31:0]   ex_imm;
  logic [31:0]   ex_rs1;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          flush_if_id;
  logic          flush_id_ex;
  logic          redirect;
  logic          misalign_err;
  logic [CW-1:0] taken_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (m_*), next state (n_*) and expected combinational outputs (e_*).
  logic [31:0]   m_pc, n_pc, m_tgt, n_tgt;
  logic          m_pend, n_pend, m_mis, n_mis;
  logic [CW-1:0] m_cnt, n_cnt;
  logic          e_redirect, e_fif, e_fie;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_stall     (if_stall),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_flag      (ex_flag),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .redirect     (redirect),
    .misalign_err (misalign_err),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    logic        ctl;
    logic        taken;
    logic [31:0] tgt;
    ctl   = (ex_opcode == 5'b11000) || (ex_opcode == 5'b11011) || (ex_opcode == 5'b11001);
    taken = ex_valid && ctl && ex_flag;
    if (ex_opcode == 5'b11001) tgt = (ex_rs1 + ex_imm) & ~32'h1;
    else                       tgt = ex_pc + ex_imm;
    e_redirect = 1'b0; e_fif = 1'b0; e_fie = 1'b0;
    n_pc = m_pc; n_pend = m_pend; n_tgt = m_tgt; n_cnt = m_cnt; n_mis = 1'b0;
    if (!rst) assert (!(m_pend && taken));
    if (rst) begin
      n_pc = 32'h0; n_pend = 1'b0; n_tgt = 32'h0; n_cnt = '0;
    end else if (m_pend) begin
      if (!if_stall) begin
        e_redirect = 1'b1; e_fif = 1'b1; n_pc = m_tgt; n_pend = 1'b0;
      end
    end else if (taken && tgt[1:0] != 2'b00) begin
      n_mis = 1'b1;
      if (!if_stall) n_pc = m_pc + 32'd4;
    end else if (taken) begin
      n_cnt = m_cnt + 1'b1;
      e_fie = 1'b1;
      if (if_stall) begin
        n_pend = 1'b1; n_tgt = tgt;
      end else begin
        e_redirect = 1'b1; e_fif = 1'b1; n_pc = tgt;
      end
    end else if (!if_stall) begin
      n_pc = m_pc + 32'd4;
    end
  endtask

  task automatic model_commit();
    m_pc = n_pc; m_pend = n_pend; m_tgt = n_tgt; m_cnt = n_cnt; m_mis = n_mis;
  endtask

  task automatic drive(input logic r, input logic st, input logic v, input logic [4:0] op,
                       input logic f, input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] rs);
    @(negedge clk);
    rst = r; if_stall = st; ex_valid = v; ex_opcode = op; ex_flag = f;
    ex_pc = p; ex_imm = im; ex_rs1 = rs;
    model_eval();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      // A taken BEQ during reset must not leak onto the combinational outputs.
      drive(i < 2, 1'b0, i < 2, 5'b11000, 1'b1, 32'h10, 32'h20, 32'h0);
      #1;
      n_checks++;
      if ({redirect, flush_if_id, flush_id_ex} !== {e_redirect, e_fif, e_fie}) begin
        n_errors++;
        $display("FAIL reset_comb[%0d]: got %b%b%b want %b%b%b", i, redirect, flush_if_id,
                 flush_id_ex, e_redirect, e_fif, e_fie);
      end
      @(posedge clk); model_commit(); #1;
      n_checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || taken_cnt !== m_cnt || misalign_err !== m_mis) begin
        n_errors++;
        $display("FAIL reset_regs[%0d]: pc=%h cnt=%0d mis=%b want pc=%h cnt=%0d mis=%b", i, pc,
                 taken_cnt, misalign_err, m_pc, m_cnt, m_mis);
      end
    end
  endtask

  task automatic test_branches();
    logic [4:0]  op  [7] = '{5'b11000, 5'b11000, 5'b11011, 5'b11001, 5'b11001, 5'b00000, 5'b01100};
    logic        fl  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] epc [7] = '{32'h10, 32'h40, 32'h40, 32'h0, 32'h0, 32'h0, 32'h44};
    logic [31:0] imm [7] = '{32'h20, 32'h8, 32'hFFFF_FFF8, 32'h4, 32'h0, 32'h0, 32'h100};
    logic [31:0] rs1 [7] = '{32'h0, 32'h0, 32'h0, 32'h101, 32'h102, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, i != 5, op[i], fl[i], epc[i], imm[i], rs1[i]);
      #1;
      n_checks++;
      if ({redirect, flush_if_id, flush_id_ex} !== {e_redirect, e_fif, e_fie}) begin
        n_errors++;
        $display("FAIL branch_comb[%0d]: got %b%b%b want %b%b%b", i, redirect, flush_if_id,
                 flush_id_ex, e_redirect, e_fif, e_fie);
      end
      @(posedge clk); model_commit(); #1;
      n_checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || taken_cnt !== m_cnt || misalign_err !== m_mis) begin
        n_errors++;
        $display("FAIL branch_regs[%0d]: pc=%h cnt=%0d mis=%b want pc=%h cnt=%0d mis=%b", i, pc,
                 taken_cnt, misalign_err, m_pc, m_cnt, m_mis);
      end
    end
    // 0x30 (BEQ), 0x34, 0x38 (JAL), 0x104 (JALR), 0x108 (bad JALR), 0x10C, 0x110 (non-control).
    n_checks++;
    if (pc !== 32'h110 || taken_cnt !== 4'd3) begin
      n_errors++;
      $display("FAIL branch_end: pc=%h cnt=%0d want pc=110 cnt=3", pc, taken_cnt);
    end
  endtask

  task automatic test_stall_pend();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i < 3, i == 0, 5'b11000, 1'b1, 32'h200, 32'h40, 32'h0);
      #1;
      n_checks++;
      if ({redirect, flush_if_id, flush_id_ex} !== {e_redirect, e_fif, e_fie}) begin
        n_errors++;
        $display("FAIL pend_comb[%0d]: got %b%b%b want %b%b%b", i, redirect, flush_if_id,
                 flush_id_ex, e_redirect, e_fif, e_fie);
      end
      @(posedge clk); model_commit(); #1;
      n_checks++;
      if (pc !== m_pc || taken_cnt !== m_cnt || misalign_err !== m_mis) begin
        n_errors++;
        $display("FAIL pend_regs[%0d]: pc=%h cnt=%0d want pc=%h cnt=%0d", i, pc, taken_cnt,
                 m_pc, m_cnt);
      end
    end
    n_checks++;
    if (pc !== 32'h244) begin
      n_errors++;
      $display("FAIL pend_end: pc=%h want 244", pc);
    end
  endtask

  task automatic test_reset_in_pend();
    for (int i = 0; i < 4; i++) begin
      drive(i == 1, i < 2, i == 0, 5'b11011, 1'b1, 32'h300, 32'h80, 32'h0);
      #1;
      n_checks++;
      if ({redirect, flush_if_id, flush_id_ex} !== {e_redirect, e_fif, e_fie}) begin
        n_errors++;
        $display("FAIL rstpend_comb[%0d]: got %b%b%b want %b%b%b", i, redirect, flush_if_id,
                 flush_id_ex, e_redirect, e_fif, e_fie);
      end
      @(posedge clk); model_commit(); #1;
      n_checks++;
      if (pc !== m_pc || taken_cnt !== m_cnt) begin
        n_errors++;
        $display("FAIL rstpend_regs[%0d]: pc=%h cnt=%0d want pc=%h cnt=%0d", i, pc, taken_cnt,
                 m_pc, m_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      drive(i == 0, 1'b0, 1'b1, 5'b11000, 1'b1, 32'h0, 32'h4, 32'h0);
      @(posedge clk); model_commit(); #1;
      if (i == 15) begin
        n_checks++;
        if (taken_cnt !== 4'hF) begin
          n_errors++;
          $display("FAIL wrap_full: cnt=%0d want 15", taken_cnt);
        end
      end
    end
    n_checks++;
    if (taken_cnt !== 4'h0) begin
      n_errors++;
      $display("FAIL wrap_zero: cnt=%0d want 0", taken_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [5] = '{5'b11000, 5'b11011, 5'b11001, 5'b01100, 5'b00100};
    logic [31:0] im;
    for (int i = 0; i < 400; i++) begin
      im = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      // Keep EX empty while a redirect is parked, as the flushed pipeline would.
      drive(1'b0, $urandom_range(0, 9) < 3, !m_pend && ($urandom_range(0, 3) != 0),
            ops[$urandom_range(0, 4)], $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
            im, $urandom);
      #1;
      n_checks++;
      if ({redirect, flush_if_id, flush_id_ex} !== {e_redirect, e_fif, e_fie}) begin
        n_errors++;
        $display("FAIL rand_comb[%0d]: got %b%b%b want %b%b%b", i, redirect, flush_if_id,
                 flush_id_ex, e_redirect, e_fif, e_fie);
      end
      @(posedge clk); model_commit(); #1;
      n_checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || taken_cnt !== m_cnt || misalign_err !== m_mis) begin
        n_errors++;
        $display("FAIL rand_regs[%0d]: pc=%h cnt=%0d mis=%b want pc=%h cnt=%0d mis=%b", i, pc,
                 taken_cnt, misalign_err, m_pc, m_cnt, m_mis);
      end
    end
  endtask

  initial begin
    rst = 1'b1; if_stall = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_flag = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    m_pc = '0; m_pend = 1'b0; m_tgt = '0; m_cnt = '0; m_mis = 1'b0;
    test_reset();
    test_branches();
    test_stall_pend();
    test_reset_in_pend();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
